// File: rtl/jt10_adpcm_pkg.sv
// Definitions shared by both ends of the ADPCM clock-enable burst link:
// the consumer state encoding and the burst shape both sides agree on.
package jt10_adpcm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        ARM,
        RUN
    } burst_state_e;

    localparam int              BURSTLEN_DEF = 7;
    localparam int              PCNT_W       = 4;
    localparam int              TCNT_W       = 4;
    localparam logic [TCNT_W-1:0] TOUT_DEF   = 4'd15;

endpackage

// File: rtl/jt10_burst_acc_dp.sv
// Burst datapath: signed sample accumulator and gated-pulse counter.
// Offers the post-pulse values combinationally so the FSM can complete on the same pulse.
module jt10_burst_acc_dp
    import jt10_adpcm_pkg::*;
#(
    parameter int DW   = 16,
    parameter int ACCW = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic              add,
    input  logic [DW-1:0]     din,
    output logic [ACCW-1:0]   acc_nxt,
    output logic [PCNT_W-1:0] pcnt_nxt
);

    logic [ACCW-1:0]   acc;
    logic [PCNT_W-1:0] pcnt;
    logic [ACCW-1:0]   din_sx;

    assign din_sx = {{(ACCW-DW){din[DW-1]}}, din};

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        acc_nxt  = acc + din_sx;
        pcnt_nxt = pcnt + PCNT_W'(1);
        if (load) begin
            acc_nxt  = din_sx;
            pcnt_nxt = PCNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc  <= '0;
            pcnt <= '0;
        end else if (clr) begin
            acc  <= '0;
            pcnt <= '0;
        end else if (load || add) begin
            acc  <= acc_nxt;
            pcnt <= pcnt_nxt;
        end
    end

endmodule

// File: rtl/jt10_burst_acc.sv
// Far-end consumer of the ADPCM burst link: requests a burst from the gate,
// sums one signed sample per gated pulse, and flags short or stray bursts.
module jt10_burst_acc
    import jt10_adpcm_pkg::*;
#(
    parameter int                BURSTLEN = BURSTLEN_DEF,
    parameter int                DW       = 16,
    parameter int                ACCW     = 20,
    parameter logic [TCNT_W-1:0] TOUT     = TOUT_DEF
) (
    input  logic            rst_n,
    input  logic            clk,
    input  logic            cen,
    input  logic            req,
    input  logic            burst_cen,
    input  logic [DW-1:0]   din,
    output logic            start,
    output logic            busy,
    output logic [ACCW-1:0] sum,
    output logic            sum_valid,
    output logic            err_short,
    output logic            err_long
);

    burst_state_e      state, state_nxt;
    logic [TCNT_W-1:0] tcnt, tcnt_nxt, tcnt_inc;
    logic [ACCW-1:0]   sum_nxt;
    logic              sum_valid_nxt, err_short_nxt, err_long_nxt;
    logic              dp_clr, dp_load, dp_add;
    logic [ACCW-1:0]   acc_nxt;
    logic [PCNT_W-1:0] pcnt_nxt;

    jt10_burst_acc_dp #(
        .DW   (DW),
        .ACCW (ACCW)
    ) u_dp (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (dp_clr),
        .load     (dp_load),
        .add      (dp_add),
        .din      (din),
        .acc_nxt  (acc_nxt),
        .pcnt_nxt (pcnt_nxt)
    );

    // Busy covers the completion pulse so a request in that clk is dropped.
    assign busy  = (state != IDLE) || sum_valid || err_short;
    assign start = (state == ARM);

    assign tcnt_inc = (tcnt == TOUT) ? tcnt : tcnt + TCNT_W'(1);

    always_comb begin
        state_nxt     = state;
        tcnt_nxt      = tcnt;
        sum_nxt       = sum;
        sum_valid_nxt = 1'b0;
        err_short_nxt = 1'b0;
        err_long_nxt  = err_long;
        dp_clr        = 1'b0;
        dp_load       = 1'b0;
        dp_add        = 1'b0;
        unique case (state)
            IDLE: begin
                if (req && !busy) begin
                    state_nxt    = GAP;
                    tcnt_nxt     = '0;
                    err_long_nxt = 1'b0;
                    dp_clr       = 1'b1;
                end
                if (burst_cen) err_long_nxt = 1'b1;
            end
            GAP: begin
                if (burst_cen) err_long_nxt = 1'b1;
                if (cen || burst_cen) state_nxt = ARM;
            end
            ARM, RUN: begin
                if (burst_cen) begin
                    dp_load  = (state == ARM);
                    dp_add   = (state == RUN);
                    tcnt_nxt = '0;
                    // A final pulse wins over a timeout landing on the same tick.
                    if (pcnt_nxt == PCNT_W'(BURSTLEN)) begin
                        sum_nxt       = acc_nxt;
                        sum_valid_nxt = 1'b1;
                        state_nxt     = IDLE;
                    end else begin
                        state_nxt = RUN;
                    end
                end else if (cen) begin
                    tcnt_nxt = tcnt_inc;
                    if (tcnt_inc == TOUT) begin
                        err_short_nxt = 1'b1;
                        state_nxt     = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            tcnt      <= '0;
            sum       <= '0;
            sum_valid <= 1'b0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
        end else begin
            state     <= state_nxt;
            tcnt      <= tcnt_nxt;
            sum       <= sum_nxt;
            sum_valid <= sum_valid_nxt;
            err_short <= err_short_nxt;
            err_long  <= err_long_nxt;
        end
    end

endmodule
